// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//
// Takes a byte stream over a valid/ready handshake and packs it into
// little-endian 32-bit words. Each word goes to instruction memory at
// consecutive byte addresses starting at BASE_ADDR. The CPU is held in
// reset-hold until the whole image has been loaded without error.
//
// Ports:
//   clock, reset_n  system clock; asynchronous active-low reset
//   start           one-cycle pulse; begins a load from IDLE, DONE or ERR
//   byte_in         stream data
//   byte_valid      byte_in valid this cycle
//   byte_last       with byte_valid, marks the final byte of the image
//   byte_ready      loader accepts a byte this cycle
//   mem_ready       instruction memory accepts the write this cycle
//   wr_en           write request (held with wr_addr/wr_data until mem_ready)
//   wr_addr         byte address of the write
//   wr_data         word to write
//   word_count      words committed in the current load
//   busy            receiving or writing
//   done            image loaded
//   error           partial word or overflow; load aborted
//   cpu_hold        low only when the image is loaded (gates PC update)
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             byte_last,
  output logic             byte_ready,
  input  logic             mem_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       byte_idx;
  logic [31:0]      buffer;
  logic             last_flag;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [31:0]      count_ext;
  logic             byte_fire;
  logic             wr_fire;
  logic             load_start;

  assign byte_fire  = (state == S_RECV) && byte_valid;
  assign wr_fire    = (state == S_WRITE) && mem_ready;
  assign load_start = start &&
                      ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign count_inc  = count + 1'b1;
  assign count_ext  = 32'(count);
  assign word_count = count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RECV;
      end
      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          // A last marker before the fourth byte leaves a partial word,
          // which is dropped rather than written.
          if (byte_idx == 2'd3) begin
            state_nxt = S_WRITE;
          end else if (byte_last) begin
            state_nxt = S_ERR;
          end
        end
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        busy    = 1'b1;
        wr_addr = BASE_ADDR + (count_ext << 2);
        wr_data = buffer;
        if (mem_ready) begin
          if (last_flag) begin
            state_nxt = S_DONE;
          end else if (count_inc == CNT_W'(MAX_WORDS)) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_RECV;
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = S_RECV;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_nxt = S_RECV;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx  <= '0;
      buffer    <= '0;
      last_flag <= 1'b0;
      count     <= '0;
    end else begin
      if (load_start) begin
        byte_idx  <= '0;
        last_flag <= 1'b0;
        count     <= '0;
      end
      if (byte_fire) begin
        buffer[{byte_idx, 3'b000} +: 8] <= byte_in;
        // 2-bit index wraps back to 0 after the fourth byte.
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) last_flag <= byte_last;
      end
      if (wr_fire) begin
        count <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed scenarios plus randomized images,
// with expected writes derived from the byte image in the bench.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_last = 1'b0;
  logic        mem_ready = 1'b1;

  logic        byte_ready, wr_en, busy, done, error, cpu_hold;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] word_count;

  logic        s_byte_ready, s_wr_en, s_busy, s_done, s_error, s_cpu_hold;
  logic [31:0] s_wr_addr, s_wr_data;
  logic [15:0] s_word_count;

  int checks = 0;
  int errors = 0;
  bit rnd_mr = 1'b0;

  logic [63:0] wlog[$];
  logic [63:0] slog[$];
  logic [7:0]  img[$];

  always #5 clock = ~clock;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024), .CNT_W(16)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
    .byte_ready(byte_ready), .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .cpu_hold(cpu_hold)
  );

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(2), .CNT_W(16)) u_small (
    .clock(clock), .reset_n(reset_n), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
    .byte_ready(s_byte_ready), .mem_ready(mem_ready),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .word_count(s_word_count), .busy(s_busy), .done(s_done), .error(s_error),
    .cpu_hold(s_cpu_hold)
  );

  // Record every committed write of both instances.
  always @(posedge clock) begin
    if (reset_n && wr_en && mem_ready) wlog.push_back({wr_addr, wr_data});
    if (reset_n && s_wr_en && mem_ready) slog.push_back({s_wr_addr, s_wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (rnd_mr) mem_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Presents a byte (valid held even while not ready) until it transfers.
  task automatic send_byte(input logic [7:0] b, input logic l);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    byte_last  = l;
    while (!byte_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("byte_ready_timeout", 32'(n), 32'd0);
    tick();
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  // Sends img[from..to], asserting byte_last on img index last_at (or none if -1).
  task automatic send_range(input int from, input int to, input int last_at, input bit gaps);
    for (int i = from; i <= to; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
      end
      send_byte(img[i], i == last_at);
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 300) begin
      tick();
      n++;
    end
    chk("end_timeout", 32'(n < 300), 32'd1);
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
  endfunction

  task automatic expect_log(input string tag, input logic [63:0] q[$], input int nwords);
    chk({tag, "_count"}, 32'(q.size()), 32'(nwords));
    for (int i = 0; i < nwords && i < q.size(); i++) begin
      chk({tag, "_addr"}, q[i][63:32], BASE + 32'(4 * i));
      chk({tag, "_data"}, q[i][31:0], model_word(i));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_s_cpu_hold"}, 32'(s_cpu_hold), 32'd1);
    chk({tag, "_s_wr_en"}, 32'(s_wr_en), 32'd0);
  endtask

  task automatic rand_img(input int len);
    img.delete();
    for (int i = 0; i < len; i++) img.push_back(8'($urandom));
  endtask

  initial begin
    int len;
    int nwords;
    bit perr;

    // Reset values and basic two-word image.
    do_reset();
    check_reset_vals("rst");
    wlog.delete();
    img = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h01, 8'h00, 8'h00, 8'h8c};
    mem_ready = 1'b1;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_byte_ready", 32'(byte_ready), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd1);
    send_range(0, 3, -1, 1'b0);
    chk("t1_lat_wr_en", 32'(wr_en), 32'd1);
    chk("t1_lat_addr", wr_addr, 32'h0040_0000);
    chk("t1_lat_data", wr_data, 32'h2000_0000);
    chk("t1_lat_not_ready", 32'(byte_ready), 32'd0);
    tick();
    chk("t1_ready_again", 32'(byte_ready), 32'd1);
    chk("t1_count1", 32'(word_count), 32'd1);
    send_range(4, 7, 7, 1'b0);
    chk("t1_w2_addr", wr_addr, 32'h0040_0004);
    chk("t1_w2_data", wr_data, 32'h8c00_0001);
    chk("t1_hold_pre", 32'(cpu_hold), 32'd1);
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_hold_post", 32'(cpu_hold), 32'd0);
    chk("t1_count", 32'(word_count), 32'd2);
    expect_log("t1_log", wlog, 2);

    // Same stream with the first write stalled for three cycles.
    wlog.delete();
    pulse_start();
    chk("t2_hold", 32'(cpu_hold), 32'd1);
    chk("t2_count0", 32'(word_count), 32'd0);
    mem_ready = 1'b0;
    send_range(0, 3, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_wr_en", 32'(wr_en), 32'd1);
      chk("t2_hold_addr", wr_addr, 32'h0040_0000);
      chk("t2_hold_data", wr_data, 32'h2000_0000);
      chk("t2_hold_ready", 32'(byte_ready), 32'd0);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    chk("t2_after_stall", 32'(word_count), 32'd1);
    send_range(4, 7, 7, 1'b0);
    wait_end();
    chk("t2_done", 32'(done), 32'd1);
    expect_log("t2_log", wlog, 2);

    // Partial final word: six bytes, last on the sixth.
    wlog.delete();
    rand_img(6);
    pulse_start();
    send_range(0, 5, 5, 1'b0);
    wait_end();
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_count", 32'(word_count), 32'd1);
    chk("t3_hold", 32'(cpu_hold), 32'd1);
    chk("t3_ready", 32'(byte_ready), 32'd0);
    expect_log("t3_log", wlog, 1);

    // Overflow on the MAX_WORDS=2 instance: 12 bytes, no last.
    wlog.delete();
    slog.delete();
    rand_img(12);
    pulse_start();
    send_range(0, 11, -1, 1'b0);
    tick();
    chk("t4_s_error", 32'(s_error), 32'd1);
    chk("t4_s_count", 32'(s_word_count), 32'd2);
    chk("t4_s_ready", 32'(s_byte_ready), 32'd0);
    chk("t4_s_hold", 32'(s_cpu_hold), 32'd1);
    expect_log("t4_slog", slog, 2);
    chk("t4_main_count", 32'(word_count), 32'd3);
    chk("t4_main_busy", 32'(busy), 32'd1);
    expect_log("t4_log", wlog, 3);

    // Asynchronous reset in the middle of word 3.
    do_reset();
    wlog.delete();
    rand_img(10);
    pulse_start();
    send_range(0, 9, -1, 1'b0);
    chk("t5_pre_count", 32'(word_count), 32'd2);
    reset_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    tick();
    reset_n = 1'b1;
    tick();
    check_reset_vals("t5_released");
    wlog.delete();
    rand_img(4);
    pulse_start();
    send_range(0, 3, 3, 1'b0);
    wait_end();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_count", 32'(word_count), 32'd1);
    expect_log("t5_log", wlog, 1);

    // Reload from DONE; start pulses while busy are ignored.
    wlog.delete();
    rand_img(4);
    pulse_start();
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    chk("t6_count0", 32'(word_count), 32'd0);
    chk("t6_not_done", 32'(done), 32'd0);
    send_range(0, 1, -1, 1'b0);
    pulse_start();
    chk("t6_busy", 32'(busy), 32'd1);
    send_range(2, 3, 3, 1'b0);
    chk("t6_writing", 32'(wr_en), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_count", 32'(word_count), 32'd1);
    chk("t6_hold_off", 32'(cpu_hold), 32'd0);
    expect_log("t6_log", wlog, 1);

    // Randomized images with random memory stalls and input gaps.
    rnd_mr = 1'b1;
    for (int it = 0; it < 30; it++) begin
      nwords = int'($urandom_range(1, 6));
      perr   = ($urandom_range(0, 3) == 0);
      len    = 4 * nwords;
      if (perr) len = len - int'($urandom_range(1, 3));
      rand_img(len);
      wlog.delete();
      pulse_start();
      chk("rnd_hold_start", 32'(cpu_hold), 32'd1);
      send_range(0, len - 1, len - 1, 1'b1);
      wait_end();
      chk("rnd_done", 32'(done), 32'(!perr));
      chk("rnd_error", 32'(error), 32'(perr));
      chk("rnd_hold", 32'(cpu_hold), 32'(perr));
      chk("rnd_count", 32'(word_count), 32'(len / 4));
      expect_log("rnd_log", wlog, len / 4);
    end
    rnd_mr = 1'b0;
    mem_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
